// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: walks pixel RAM per frame and serves G,R,B bytes to a WS2812 shifter.
// Define WS2812_BRIGHTNESS_EN to scale each channel by (brightness+1)/256 at pixel load.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS = 16,
  parameter int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    brightness,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [23:0]   pix_data,
  output logic          sh_trigger,
  input  logic          sh_data_request,
  output logic [7:0]    sh_data,
  output logic          sh_data_valid,
  output logic          busy,
  output logic          frame_done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SERVE, DRAIN} state_t;
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);
  state_t state;
  logic [23:0] pix;
  logic [23:0] px;
  logic [1:0] byte_idx;
`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c);
    logic [15:0] p;
    p = 16'(c) * (16'(brightness) + 16'd1);
    return 8'(p >> 8);
  endfunction
  assign px = {scale(pix_data[23:16]), scale(pix_data[15:8]), scale(pix_data[7:0])};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign px = pix_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pix_rd <= 1'b0;
      pix_addr <= '0;
      pix <= '0;
      byte_idx <= 2'd0;
      sh_trigger <= 1'b0;
      sh_data <= 8'd0;
      sh_data_valid <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // trigger is held until the shifter first asks for data, covering its reset tail
      if (sh_trigger && sh_data_request) sh_trigger <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          pix_addr <= '0;
          pix_rd <= 1'b1;
          busy <= 1'b1;
          sh_trigger <= 1'b1;
        end
        FETCH: begin
          pix_rd <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          pix <= px;
          sh_data <= px[15:8];
          sh_data_valid <= 1'b1;
          byte_idx <= 2'd0;
          state <= SERVE;
        end
        SERVE: if (sh_data_request) begin
          if (byte_idx != 2'd2) begin
            byte_idx <= byte_idx + 2'd1;
            sh_data <= (byte_idx == 2'd0) ? pix[23:16] : pix[7:0];
          end else begin
            sh_data_valid <= 1'b0;
            if (pix_addr == LAST) state <= DRAIN;
            else begin
              pix_addr <= pix_addr + AW'(1);
              pix_rd <= 1'b1;
              state <= FETCH;
            end
          end
        end
        DRAIN: if (sh_data_request) begin
          frame_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          pix_rd <= 1'b0;
          sh_data_valid <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// tb_ws2812_frame_sequencer: directed checks on a 2-LED and a 1-LED sequencer with RAM and shifter models.
module tb_ws2812_frame_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, sel, req;
  logic start_a, pix_rd_a, pix_data_valid_dummy, trig_a, req_a, valid_a, busy_a, done_a;
  logic start_b, pix_rd_b, trig_b, req_b, valid_b, busy_b, done_b;
  logic [7:0] brightness_a, brightness_b, data_a, data_b;
  logic [0:0] addr_a, addr_b;
  logic [23:0] pix_data_a, pix_data_b;
  logic [23:0] ram_a [2] = '{24'h112233, 24'h445566};
  logic [23:0] ram_b [2] = '{24'hFF8001, 24'h000000};
  logic cur_valid, cur_busy, cur_done;
  logic [7:0] cur_data;
  int n_tests = 0, n_fail = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [7:0] e0, e1, e2;
  ws2812_frame_sequencer #(.NUM_LEDS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .brightness(brightness_a),
    .pix_rd(pix_rd_a), .pix_addr(addr_a), .pix_data(pix_data_a),
    .sh_trigger(trig_a), .sh_data_request(req_a), .sh_data(data_a),
    .sh_data_valid(valid_a), .busy(busy_a), .frame_done(done_a));
  ws2812_frame_sequencer #(.NUM_LEDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .brightness(brightness_b),
    .pix_rd(pix_rd_b), .pix_addr(addr_b), .pix_data(pix_data_b),
    .sh_trigger(trig_b), .sh_data_request(req_b), .sh_data(data_b),
    .sh_data_valid(valid_b), .busy(busy_b), .frame_done(done_b));
  assign req_a = req & ~sel;
  assign req_b = req & sel;
  assign cur_valid = sel ? valid_b : valid_a;
  assign cur_data = sel ? data_b : data_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;
  always @(posedge clk) begin
    if (pix_rd_a) pix_data_a <= ram_a[addr_a];
    if (pix_rd_b) pix_data_b <= ram_b[addr_b];
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_valid();
    for (int w = 0; w < 8 && !cur_valid; w++) @(negedge clk);
  endtask
  task automatic get_byte(input string tag, input logic [7:0] exp);
    wait_valid();
    check({tag, " valid"}, 32'(cur_valid), 32'd1);
    check(tag, 32'(cur_data), 32'(exp));
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask
  task automatic finish_frame(input string tag);
    check({tag, " term valid"}, 32'(cur_valid), 32'd0);
    check({tag, " busy before"}, 32'(cur_busy), 32'd1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({tag, " done pulse"}, 32'(cur_done), 32'd1);
    check({tag, " busy fall"}, 32'(cur_busy), 32'd0);
    @(negedge clk);
    check({tag, " done low"}, 32'(cur_done), 32'd0);
  endtask
  task automatic start_pulse();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask
  task automatic frame_a(input string tag);
    get_byte({tag, " b0"}, 8'h22);
    get_byte({tag, " b1"}, 8'h11);
    get_byte({tag, " b2"}, 8'h33);
    get_byte({tag, " b3"}, 8'h55);
    get_byte({tag, " b4"}, 8'h44);
    get_byte({tag, " b5"}, 8'h66);
    finish_frame(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; sel = 1'b0; req = 1'b0; start_a = 1'b0; start_b = 1'b0;
    brightness_a = 8'hFF; brightness_b = 8'h7F;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({pix_rd_a, addr_a, trig_a, data_a, valid_a, busy_a, done_a}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    check("n+1 pix_rd", 32'(pix_rd_a), 32'd1);
    check("n+1 pix_addr", 32'(addr_a), 32'd0);
    check("n+1 busy", 32'(busy_a), 32'd1);
    check("n+1 trigger", 32'(trig_a), 32'd1);
    check("n+1 valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    check("n+2 pix_rd", 32'(pix_rd_a), 32'd0);
    check("n+2 valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    check("n+3 valid", 32'(valid_a), 32'd1);
    check("n+3 data G", 32'(data_a), 32'h22);
    check("trigger before req", 32'(trig_a), 32'd1);
    get_byte("f1 b0", 8'h22);
    check("trigger after req", 32'(trig_a), 32'd0);
    start_a = 1'b1;
    get_byte("f1 b1", 8'h11);
    get_byte("f1 b2", 8'h33);
    start_a = 1'b0;
    get_byte("f1 b3", 8'h55);
    get_byte("f1 b4", 8'h44);
    get_byte("f1 b5", 8'h66);
    finish_frame("f1");
    check("f1 done count", 32'(done_cnt_a), 32'd1);
    start_pulse();
    get_byte("rst b0", 8'h22);
    get_byte("rst b1", 8'h11);
    get_byte("rst b2", 8'h33);
    wait_valid();
    check("rst b3 before reset", 32'(data_a), 32'h55);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({pix_rd_a, addr_a, trig_a, data_a, valid_a, busy_a, done_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no done on reset", 32'(done_cnt_a), 32'd1);
    start_pulse();
    check("replay pix_addr", 32'(addr_a), 32'd0);
    frame_a("replay");
    check("replay done count", 32'(done_cnt_a), 32'd2);
    sel = 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
    e0 = 8'h40; e1 = 8'h7F; e2 = 8'h00;
`else
    e0 = 8'h80; e1 = 8'hFF; e2 = 8'h01;
`endif
    start_pulse();
    get_byte("one b0", e0);
    get_byte("one b1", e1);
    get_byte("one b2", e2);
    finish_frame("one");
    brightness_b = 8'hFF;
    start_pulse();
    get_byte("full b0", 8'h80);
    get_byte("full b1", 8'hFF);
    get_byte("full b2", 8'h01);
    finish_frame("full");
    check("one done count", 32'(done_cnt_b), 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
